// File: rtl/gates_stim_seq_pkg.sv
// Package: gates_stim_pkg
// Shared definitions for the gates_stim_seq stimulus sequencer:
//   - state_e   : FSM state encodings
//   - NUM_VEC   : number of vectors in one sweep (all 4-bit combinations)
//   - LAST_IDX  : index of the final vector of a sweep
//   - bin2gray4 : 4-bit binary to reflected Gray code conversion
package gates_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int         NUM_VEC  = 16;
  localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

  // Reflected Gray code: each bit is the XOR of itself and the next higher bit.
  function automatic logic [3:0] bin2gray4(input logic [3:0] bin);
    return bin ^ {1'b0, bin[3:1]};
  endfunction

endpackage

// File: rtl/gates_stim_seq_hold_cnt.sv
// Module: stim_hold_cnt
// Dwell hold counter for the stimulus sequencer.
// Ports:
//   clk, reset_n : clock and synchronous active-low reset
//   clr          : force the counter to zero on the next edge (wins over en)
//   en           : increment the counter on the next edge
//   limit        : terminal value to compare against
//   count_nx     : value the counter will hold after the next edge
//   term         : current count equals limit
module stim_hold_cnt #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] limit,
  output logic [DWELL_W-1:0] count_nx,
  output logic               term
);

  logic [DWELL_W-1:0] count_r;

  // Next-count selection; exposed so the parent can register a strobe
  // that lines up with the new count.
  always_comb begin
    count_nx = count_r;
    if (clr) begin
      count_nx = {DWELL_W{1'b0}};
    end else if (en) begin
      count_nx = count_r + DWELL_W'(1);
    end else begin
      count_nx = count_r;
    end
  end

  // Terminal flag from the registered count.
  always_comb begin
    term = (count_r == limit);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r <= {DWELL_W{1'b0}};
    end else begin
      count_r <= count_nx;
    end
  end

endmodule

// File: rtl/gates_stim_seq.sv
// Module: gates_stim_seq
// Clocked sweep of all 16 {a,b,c,d} combinations (binary or Gray order) for
// the gates block, holding each vector dwell+1 cycles.
// Ports:
//   clk, reset_n : clock and synchronous active-low reset
//   start        : begin a sweep (accepted only in IDLE; beats abort there)
//   abort        : cancel a running sweep, no done pulse
//   gray         : 1 = Gray order, 0 = binary; latched at accepted start
//   loop         : sampled at the end of vector 15; 1 restarts at vector 0
//   dwell        : extra hold cycles per vector; latched at accepted start
//   a, b, c, d   : registered stimulus, a is the MSB of the code
//   vec_idx      : index of the vector currently driven
//   busy         : high while sweeping
//   sample       : high on the last hold cycle of each vector
//   done         : one-cycle pulse after a non-looping sweep completes
module gates_stim_seq
  import gates_stim_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               gray,
  input  logic               loop,
  input  logic [DWELL_W-1:0] dwell,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic [3:0]         vec_idx,
  output logic               busy,
  output logic               sample,
  output logic               done
);

  state_e             state_r,   state_nx_s;
  logic [3:0]         idx_r,     idx_nx_s;
  logic [DWELL_W-1:0] dwell_q_r, dwell_nx_s;
  logic               gray_q_r,  gray_nx_s;
  logic               cnt_clr_s, cnt_en_s, term_s;
  logic [DWELL_W-1:0] cnt_nx_s;
  logic               done_nx_s, sample_nx_s;
  logic [3:0]         code_nx_s;

  logic [3:0]         code_r, vec_idx_r;
  logic               busy_r, sample_r, done_r;

  stim_hold_cnt #(.DWELL_W(DWELL_W)) u_hold_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (cnt_clr_s),
    .en       (cnt_en_s),
    .limit    (dwell_q_r),
    .count_nx (cnt_nx_s),
    .term     (term_s)
  );

  // Next-state, index and hold-counter control.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    dwell_nx_s = dwell_q_r;
    gray_nx_s  = gray_q_r;
    cnt_clr_s  = 1'b0;
    cnt_en_s   = 1'b0;
    done_nx_s  = 1'b0;
    case (state_r)
      IDLE: begin
        idx_nx_s  = 4'd0;
        cnt_clr_s = 1'b1;
        if (start) begin
          dwell_nx_s = dwell;
          gray_nx_s  = gray;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx_s = IDLE;
          idx_nx_s   = 4'd0;
          cnt_clr_s  = 1'b1;
        end else if (!term_s) begin
          cnt_en_s = 1'b1;
        end else if (idx_r != LAST_IDX) begin
          idx_nx_s  = idx_r + 4'd1;
          cnt_clr_s = 1'b1;
        end else if (loop) begin
          idx_nx_s  = 4'd0;
          cnt_clr_s = 1'b1;
        end else begin
          state_nx_s = DONE;
          idx_nx_s   = 4'd0;
          cnt_clr_s  = 1'b1;
          done_nx_s  = 1'b1;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
        idx_nx_s   = 4'd0;
        cnt_clr_s  = 1'b1;
      end
      default: begin
        state_nx_s = IDLE;
        idx_nx_s   = 4'd0;
        cnt_clr_s  = 1'b1;
      end
    endcase
  end

  // Output values for the next cycle, derived from next-state values so the
  // registered outputs line up with the state they describe. Outside RUN the
  // index is forced to 0, and code(0) is 0 in either order.
  always_comb begin
    if (gray_nx_s) begin
      code_nx_s = bin2gray4(idx_nx_s);
    end else begin
      code_nx_s = idx_nx_s;
    end
    sample_nx_s = (state_nx_s == RUN) && (cnt_nx_s == dwell_nx_s);
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      idx_r     <= 4'd0;
      dwell_q_r <= {DWELL_W{1'b0}};
      gray_q_r  <= 1'b0;
      code_r    <= 4'd0;
      vec_idx_r <= 4'd0;
      busy_r    <= 1'b0;
      sample_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      idx_r     <= idx_nx_s;
      dwell_q_r <= dwell_nx_s;
      gray_q_r  <= gray_nx_s;
      code_r    <= code_nx_s;
      vec_idx_r <= idx_nx_s;
      busy_r    <= (state_nx_s == RUN);
      sample_r  <= sample_nx_s;
      done_r    <= done_nx_s;
    end
  end

  assign a       = code_r[3];
  assign b       = code_r[2];
  assign c       = code_r[1];
  assign d       = code_r[0];
  assign vec_idx = vec_idx_r;
  assign busy    = busy_r;
  assign sample  = sample_r;
  assign done    = done_r;

endmodule

// File: tb/tb_gates_stim_seq.sv
module tb_gates_stim_seq;

  logic       clk = 1'b0;
  logic       reset_n, start, abort, gray, loop;
  logic [7:0] dwell;
  logic       a, b, c, d, busy, sample, done;
  logic [3:0] vec_idx;
  logic [3:0] code;
  int         total = 0;
  int         bad   = 0;

  assign code = {a, b, c, d};

  gates_stim_seq #(.DWELL_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .gray(gray),
    .loop(loop), .dwell(dwell), .a(a), .b(b), .c(c), .d(d),
    .vec_idx(vec_idx), .busy(busy), .sample(sample), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; abort = 1'b0; gray = 1'b1; loop = 1'b0; dwell = 8'd3;
    step(); step();
    total++;
    if ({code, vec_idx, busy, sample, done} !== 11'd0) begin
      bad++; $display("FAIL reset_state: got code=%b idx=%0d busy=%b sample=%b done=%b want all 0",
                      code, vec_idx, busy, sample, done);
    end
    reset_n = 1'b1; start = 1'b0; gray = 1'b0; dwell = 8'd0;
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: busy=%b want 0", busy); end
  endtask

  task automatic test_binary();
    dwell = 8'd0; gray = 1'b0; loop = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (code !== i[3:0] || vec_idx !== i[3:0] || busy !== 1'b1 || sample !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL bin_vec%0d: got code=%b idx=%0d busy=%b sample=%b done=%b want code=%b busy=1 sample=1 done=0",
                        i, code, vec_idx, busy, sample, done, i[3:0]);
      end
      step();
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || code !== 4'd0 || sample !== 1'b0) begin
      bad++; $display("FAIL bin_done: got done=%b busy=%b code=%b sample=%b want 1 0 0000 0", done, busy, code, sample);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL bin_done_once: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_gray();
    logic [3:0] gexp [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    int nsamp = 0;
    dwell = 8'd2; gray = 1'b1; start = 1'b1;
    step();
    start = 1'b0; gray = 1'b0; dwell = 8'd0;
    for (int i = 0; i < 16; i++) begin
      for (int h = 0; h < 3; h++) begin
        if (sample === 1'b1) nsamp++;
        total++;
        if (code !== gexp[i] || vec_idx !== i[3:0] || sample !== (h == 2) || busy !== 1'b1) begin
          bad++; $display("FAIL gray_v%0d_h%0d: got code=%b idx=%0d sample=%b busy=%b want code=%b sample=%b",
                          i, h, code, vec_idx, sample, busy, gexp[i], (h == 2));
        end
        step();
      end
    end
    total++;
    if (nsamp != 16) begin bad++; $display("FAIL gray_samples: got %0d want 16", nsamp); end
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL gray_done: got done=%b busy=%b want 1 0", done, busy);
    end
    step();
  endtask

  task automatic test_abort();
    dwell = 8'd3; gray = 1'b0; loop = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 29; i++) step();
    total++;
    if (vec_idx !== 4'd7 || code !== 4'b0111 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_pre: got idx=%0d code=%b busy=%b want 7 0111 1", vec_idx, code, busy);
    end
    abort = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || code !== 4'd0 || vec_idx !== 4'd0 || done !== 1'b0 || sample !== 1'b0) begin
      bad++; $display("FAIL abort_quiet: got busy=%b code=%b idx=%0d done=%b sample=%b want all 0",
                      busy, code, vec_idx, done, sample);
    end
    start = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b1 || vec_idx !== 4'd0 || code !== 4'd0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_restart: got busy=%b idx=%0d code=%b done=%b want 1 0 0000 0",
                      busy, vec_idx, code, done);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL abort_nodone%0d: got done=%b busy=%b want 0 0", i, done, busy);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    dwell = 8'd0; gray = 1'b0; loop = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    total++;
    if (vec_idx !== 4'd9 || busy !== 1'b1) begin
      bad++; $display("FAIL rst_pre: got idx=%0d busy=%b want 9 1", vec_idx, busy);
    end
    reset_n = 1'b0; start = 1'b1;
    step();
    total++;
    if ({code, vec_idx, busy, sample, done} !== 11'd0) begin
      bad++; $display("FAIL rst_mid: got code=%b idx=%0d busy=%b sample=%b done=%b want all 0",
                      code, vec_idx, busy, sample, done);
    end
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_start_ignored: busy=%b want 0", busy); end
    reset_n = 1'b1; start = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rst_after: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_loop();
    dwell = 8'd0; gray = 1'b0; loop = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    total++;
    if (vec_idx !== 4'd15 || code !== 4'b1111) begin
      bad++; $display("FAIL loop_v15: got idx=%0d code=%b want 15 1111", vec_idx, code);
    end
    step();
    total++;
    if (vec_idx !== 4'd0 || busy !== 1'b1 || done !== 1'b0 || code !== 4'd0) begin
      bad++; $display("FAIL loop_wrap: got idx=%0d busy=%b done=%b code=%b want 0 1 0 0000",
                      vec_idx, busy, done, code);
    end
    loop = 1'b0;
    for (int i = 0; i < 15; i++) step();
    total++;
    if (vec_idx !== 4'd15 || sample !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL loop_last: got idx=%0d sample=%b busy=%b want 15 1 1", vec_idx, sample, busy);
    end
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL loop_done: got done=%b busy=%b want 1 0", done, busy);
    end
    step();
  endtask

  task automatic test_back_to_back();
    dwell = 8'd1; gray = 1'b0; loop = 1'b0; start = 1'b1;
    step();
    dwell = 8'd5;
    step();
    total++;
    if (vec_idx !== 4'd0 || sample !== 1'b1) begin
      bad++; $display("FAIL b2b_hold: got idx=%0d sample=%b want 0 1", vec_idx, sample);
    end
    step();
    total++;
    if (vec_idx !== 4'd1 || sample !== 1'b0) begin
      bad++; $display("FAIL b2b_dwell_kept: got idx=%0d sample=%b want 1 0", vec_idx, sample);
    end
    for (int i = 0; i < 29; i++) step();
    total++;
    if (vec_idx !== 4'd15 || sample !== 1'b1) begin
      bad++; $display("FAIL b2b_last: got idx=%0d sample=%b want 15 1", vec_idx, sample);
    end
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_done: got done=%b busy=%b want 1 0", done, busy);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: got done=%b busy=%b want 0 0", done, busy);
    end
    step();
    total++;
    if (busy !== 1'b1 || vec_idx !== 4'd0 || sample !== 1'b0) begin
      bad++; $display("FAIL b2b_restart: got busy=%b idx=%0d sample=%b want 1 0 0", busy, vec_idx, sample);
    end
    for (int i = 0; i < 5; i++) step();
    total++;
    if (vec_idx !== 4'd0 || sample !== 1'b1) begin
      bad++; $display("FAIL b2b_new_dwell: got idx=%0d sample=%b want 0 1", vec_idx, sample);
    end
    step();
    total++;
    if (vec_idx !== 4'd1) begin bad++; $display("FAIL b2b_new_adv: got idx=%0d want 1", vec_idx); end
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_abort: busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_gray();
    test_abort();
    test_reset_mid();
    test_loop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gates_stim_seq.md
# gates_stim_seq

Stimulus sequencer that sits directly upstream of the built-in-gates block and drives its four inputs a, b, c, d. On a start request it steps through all 16 input combinations in binary or Gray order. Each vector is held for a programmable number of cycles, and a sample strobe marks the last cycle of each vector so a downstream checker can capture settled gate outputs. It replaces hand-written delay stimulus with a deterministic, clocked sweep.

## Interface
Parameters:
- DWELL_W, 8, width of the dwell-count input and the internal hold counter.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  sweep request; honoured only in IDLE.
- abort  in  1  synchronous cancel; honoured only in RUN.
- gray  in  1  order select: 0 = binary, 1 = Gray; latched at accepted start.
- loop  in  1  when 1 at the end of vector 15, restart at vector 0 instead of finishing.
- dwell  in  DWELL_W  extra hold cycles per vector; latched at accepted start.
- a, b, c, d  out  1 each  gate-block stimulus, registered; {a,b,c,d} = code, a is MSB.
- vec_idx  out  4  index of the vector currently driven.
- busy  out  1  high in RUN.
- sample  out  1  one-cycle strobe on the last hold cycle of each vector.
- done  out  1  one-cycle pulse when a non-looping sweep completes.

## Operation
- States:
  - IDLE: outputs quiescent; start=1 loads dwell_q and gray_q, then goes to RUN with idx=0 and hold counter 0.
  - RUN: holds idx while the counter is below dwell_q, incrementing the counter each cycle.
  - DONE: done=1 for one cycle, then returns to IDLE unconditionally.
- RUN exits:
  - When the counter equals dwell_q and idx < 15: idx+1, counter 0.
  - When idx = 15 and loop = 1: idx wraps to 0, counter 0, stay in RUN.
  - When idx = 15 and loop = 0: go to DONE.
  - abort = 1 goes to IDLE, has priority over every other RUN transition, and produces no done.
- Code: binary = idx; Gray = idx ^ (idx >> 1), 4-bit.
- Each vector lasts dwell_q + 1 cycles. dwell = 0 gives one cycle per vector; the maximum is 2^DWELL_W cycles.
- start in RUN or DONE is ignored; start and abort together in IDLE means start wins.
- Changes to dwell, gray and loop during RUN have no effect, except loop, which is sampled at the end of vector 15.

## Timing
- Reset (reset_n=0 at an edge) forces, from the next cycle: state IDLE; a, b, c, d, vec_idx, busy, sample, done = 0; dwell_q = 0; gray_q = 0. This applies mid-sweep with no done.
- In IDLE and DONE: a, b, c, d = 0 and vec_idx = 0.
- All outputs are registered, with no combinational paths from inputs to outputs.
- Start latency: with start high at edge N, busy=1 and vector 0 is driven from cycle N+1.
- sample is high in the cycle where the counter equals dwell_q. The vector stays stable through that cycle and changes on the following edge.
- done is high exactly one cycle, in the cycle after the last sample of vector 15; busy = 0 in that cycle.
- Abort latency: with abort high at edge M, outputs are quiescent from cycle M+1.
- Timing for a full non-looping sweep starting at edge 0: RUN occupies 16·(dwell+1) cycles, and done occurs at cycle 16·(dwell+1)+1.

## Structure
- Package gates_stim_pkg holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the vector count constant NUM_VEC=16;
  - the function bin2gray4.
- Sub-module stim_hold_cnt: a DWELL_W-bit counter with clear/enable inputs and a terminal flag (count == limit). The top-level FSM, index register and output registers live in gates_stim_seq.

## Test plan
- Binary sweep, dwell=0, gray=0, loop=0, start at cycle 0:
  - {a,b,c,d} = 0000, 0001, … 1111 on cycles 1–16; sample high on cycles 1–16.
  - done high on cycle 17 only; outputs 0 from cycle 17.
- Gray sweep, dwell=2:
  - Each vector is held 3 cycles; vec_idx 5 drives 0111 and vec_idx 15 drives 1000.
  - 16 sample pulses spaced 3 apart; done at cycle 49.
- Abort during vec_idx=7 (dwell=3):
  - The next cycle has busy=0, outputs 0000 and no done pulse.
  - A start asserted with abort in the same IDLE cycle begins a new sweep at vector 0.
- reset_n low mid-sweep at vec_idx=9:
  - All outputs are 0 the next cycle; no done.
  - start is ignored while reset_n is low.
- Loop=1, dwell=0:
  - vec_idx goes 15 → 0 with no DONE cycle and busy staying 1.
  - After loop is dropped, done fires one cycle after the next vector-15 sample.
- start held high continuously with dwell=1:
  - Back-to-back sweeps separated by exactly one DONE cycle plus one IDLE cycle.
  - Changing dwell mid-sweep has no effect until the next start.
